// File: rtl/tetris_board_renderer.sv
// Tetris playfield renderer: 10x20 board of 3-bit colour cells, drawn with a white frame, 2-cycle latency.
// Optional build macro TETRIS_GRID_LINES_EN draws dark grey cell grid lines over the playfield.
module tetris_board_renderer #(
    parameter int BOARD_X0  = 240,
    parameter int BOARD_Y0  = 80,
    parameter int CELL_LOG2 = 4
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       de_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [2:0] wr_data,
    output logic [7:0] red_o,
    output logic [7:0] green_o,
    output logic [7:0] blue_o,
    output logic       de_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       busy,
    output logic       frame_start
);
    localparam int          CELLS = 200;
    localparam logic [10:0] X_LO  = 11'(BOARD_X0);
    localparam logic [10:0] X_HI  = 11'(BOARD_X0 + (10 << CELL_LOG2));
    localparam logic [10:0] Y_LO  = 11'(BOARD_Y0);
    localparam logic [10:0] Y_HI  = 11'(BOARD_Y0 + (20 << CELL_LOG2));

    function automatic logic [23:0] palette(input logic [2:0] c);
        case (c)
            3'd0:    palette = 24'h000000;
            3'd1:    palette = 24'h00FFFF;
            3'd2:    palette = 24'hFFFF00;
            3'd3:    palette = 24'hA000F0;
            3'd4:    palette = 24'h00F000;
            3'd5:    palette = 24'hF00000;
            3'd6:    palette = 24'h0000F0;
            default: palette = 24'hF0A000;
        endcase
    endfunction

    // Post-reset board clear sweeps cells 0..199, one per cycle
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic       busy_q, busy_d;

    always_comb begin
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        if (busy_q) begin
            clr_cnt_d = clr_cnt_q + 8'd1;
            if (clr_cnt_q == 8'(CELLS - 1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;

    // Stage 0: geometry decode of the incoming pixel
    logic [10:0] xe, ye, dx, dy;
    logic        in_x, in_y, ring_x, ring_y;
    logic        inside_d, border_d;
    logic [7:0]  rd_addr_d;

    assign xe       = {1'b0, x_i};
    assign ye       = {1'b0, y_i};
    assign dx       = xe - X_LO;
    assign dy       = ye - Y_LO;
    assign in_x     = (xe >= X_LO) && (xe < X_HI);
    assign in_y     = (ye >= Y_LO) && (ye < Y_HI);
    // +1 on the low side keeps the ring test valid when the board touches column/row 0
    assign ring_x   = (xe + 11'd1 >= X_LO) && (xe <= X_HI);
    assign ring_y   = (ye + 11'd1 >= Y_LO) && (ye <= Y_HI);
    assign inside_d = in_x && in_y;
    assign border_d = ring_x && ring_y && !inside_d;
    assign rd_addr_d = inside_d ? 8'((dy >> CELL_LOG2) * 11'd10 + (dx >> CELL_LOG2)) : 8'd0;

    // Board store: clear sweep has priority over game writes; read returns pre-write data
    logic [2:0] mem [CELLS];
    logic [2:0] rd_q;

    always_ff @(posedge pixclk) begin
        if (busy_q && !rst)
            mem[clr_cnt_q] <= 3'd0;
        else if (wr_en && !busy_q && (wr_addr < 8'(CELLS)))
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr_d];
    end

    // Stage 1
    logic in_q, bd_q, bsy1_q, de1_q, hs1_q, vs1_q;
    logic grid1;

    always_ff @(posedge pixclk) begin
        if (rst) begin
            in_q   <= 1'b0;
            bd_q   <= 1'b0;
            bsy1_q <= 1'b0;
            de1_q  <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
        end else begin
            in_q   <= inside_d;
            bd_q   <= border_d;
            bsy1_q <= busy_q;
            de1_q  <= de_i;
            hs1_q  <= hsync_i;
            vs1_q  <= vsync_i;
        end
    end

`ifdef TETRIS_GRID_LINES_EN
    logic grid_q, grid_d;
    assign grid_d = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
    always_ff @(posedge pixclk) begin
        if (rst) grid_q <= 1'b0;
        else     grid_q <= grid_d;
    end
    assign grid1 = grid_q;
`else
    assign grid1 = 1'b0;
`endif

    // Stage 2: colour select
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, hs_q, vs_q, fs_q, fs_d;

    always_comb begin
        rgb_d = 24'h000000;
        if (de1_q) begin
            if (in_q) begin
                if (grid1)       rgb_d = 24'h202020;
                else if (bsy1_q) rgb_d = palette(3'd0);
                else             rgb_d = palette(rd_q);
            end else if (bd_q) begin
                rgb_d = 24'hFFFFFF;
            end
        end
    end

    assign fs_d = vs1_q && !vs_q;

    always_ff @(posedge pixclk) begin
        if (rst) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= de1_q;
            hs_q  <= hs1_q;
            vs_q  <= vs1_q;
            fs_q  <= fs_d;
        end
    end

    assign red_o       = rgb_q[23:16];
    assign green_o     = rgb_q[15:8];
    assign blue_o      = rgb_q[7:0];
    assign de_o        = de_q;
    assign hsync_o     = hs_q;
    assign vsync_o     = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_tetris_board_renderer.sv
// Bench for tetris_board_renderer: random and directed pixels/writes against a board-level model.
module tb_tetris_board_renderer;
    localparam int X0 = 240;
    localparam int Y0 = 80;
    localparam int CS = 16;

    logic       pixclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x_i = '0, y_i = '0;
    logic       de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [2:0] wr_data = '0;
    logic [7:0] red_o, green_o, blue_o;
    logic       de_o, hsync_o, vsync_o, busy, frame_start;

    tetris_board_renderer #(.BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_LOG2(4)) dut (
        .pixclk(pixclk), .rst(rst), .x_i(x_i), .y_i(y_i),
        .de_i(de_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .busy(busy), .frame_start(frame_start)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        logic [23:0] rgb;
        logic        de, hs, vs, fs;
        bit          chk;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic [2:0]  board [200];
    logic [23:0] pal [8] = '{24'h000000, 24'h00FFFF, 24'hFFFF00, 24'hA000F0,
                             24'h00F000, 24'hF00000, 24'h0000F0, 24'hF0A000};
    int          clr_left = 0;
    int          busy_run = 0;
    bit          arm = 0;
    logic        vs_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int x, input int y, input bit de, input bit bsy);
        if (!de) return 24'h000000;
        if (x >= X0 && x < X0 + 10*CS && y >= Y0 && y < Y0 + 20*CS) begin
`ifdef TETRIS_GRID_LINES_EN
            if ((x - X0) % CS == 0 || (y - Y0) % CS == 0) return 24'h202020;
`endif
            if (bsy) return 24'h000000;
            return pal[board[((y - Y0) / CS) * 10 + (x - X0) / CS]];
        end
        if (x >= X0 - 1 && x <= X0 + 10*CS && y >= Y0 - 1 && y <= Y0 + 20*CS) return 24'hFFFFFF;
        return 24'h000000;
    endfunction

    // One pixel clock: check busy, drive inputs, queue the response due two edges later
    task automatic cyc(input bit r, input int x, input int y, input bit de, input bit hs,
                       input bit vs, input bit we, input int wa, input int wd);
        exp_t e;
        bit   bm;
        @(negedge pixclk);
        bm = (clr_left > 0);
        if (arm) begin
            chk("busy", {31'd0, busy}, {31'd0, bm});
            if (r) busy_run = 0;
            else if (busy) busy_run++;
            else if (busy_run > 0) begin
                chk("busy_len", busy_run, 200);
                busy_run = 0;
            end
        end
        rst = r; x_i = 10'(x); y_i = 10'(y);
        de_i = de; hsync_i = hs; vsync_i = vs;
        wr_en = we; wr_addr = 8'(wa); wr_data = 3'(wd);
        if (r) begin
            e = '{24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            if (q.size() > 0) begin
                q[q.size()-1].rgb = '0;
                q[q.size()-1].de  = 1'b0;
                q[q.size()-1].hs  = 1'b0;
                q[q.size()-1].vs  = 1'b0;
                q[q.size()-1].fs  = 1'b0;
            end
            arm = 1;
            vs_prev = 1'b0;
        end else begin
            e.rgb = ref_rgb(x, y, de, bm);
            e.de = de; e.hs = hs; e.vs = vs;
            e.fs = vs && !vs_prev;
            e.chk = arm;
            vs_prev = vs;
        end
        q.push_back(e);
        if (r) clr_left = 200;
        else if (clr_left > 0) begin
            board[200 - clr_left] = 3'd0;
            clr_left--;
        end else if (we && wa < 200) board[wa] = 3'(wd);
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pix(input int x, input int y);
        cyc(0, x, y, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        cyc(0, 0, 0, 0, 0, 0, 1, a, d);
    endtask

    always @(posedge pixclk) begin
        exp_t e;
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            if (e.chk) begin
                chk("rgb", {8'd0, red_o, green_o, blue_o}, {8'd0, e.rgb});
                chk("flags", {28'd0, de_o, hsync_o, vsync_o, frame_start},
                    {28'd0, e.de, e.hs, e.vs, e.fs});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) idle(1);
        repeat (205) idle(0);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                pix(X0 + c*CS + 8, Y0 + r*CS + 8);

        wr(0, 5);
        pix(X0 + 3, Y0 + 3);
        pix(X0 - 1, Y0 + 5);
        pix(0, 0);
        pix(X0 + 10*CS, Y0 + 20*CS);
        pix(X0 + 10*CS - 1, Y0 - 1);

        wr(200, 7);
        pix(X0 + 9*CS + 4, Y0 + 19*CS + 4);
        wr(199, 7);
        pix(X0 + 9*CS + 4, Y0 + 19*CS + 4);
        cyc(0, X0 + 9*CS + 4, Y0 + 19*CS + 4, 1, 0, 0, 1, 199, 3);
        pix(X0 + 9*CS + 4, Y0 + 19*CS + 4);

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            int x, y;
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                x = $urandom_range(X0 - 20, X0 + 10*CS + 20);
                y = $urandom_range(Y0 - 20, Y0 + 20*CS + 20);
            end
            cyc(0, x, y, $urandom_range(0, 5) != 0, $urandom_range(0, 1),
                $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                $urandom_range(0, 215), $urandom_range(0, 7));
        end

        repeat (2) idle(0);
        idle(1);
        for (int i = 0; i < 100; i++) begin
            if (i == 5 || i == 6) pix(X0 + 9*CS + 4, Y0 + 19*CS + 4);
            else idle(0);
        end
        idle(1);
        repeat (205) idle(0);
        for (int i = 0; i < 100; i++)
            pix($urandom_range(X0 - 2, X0 + 10*CS + 1), $urandom_range(Y0 - 2, Y0 + 20*CS + 1));

        repeat (4) idle(0);
        @(negedge pixclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tetris_board_renderer.md
TETRIS_BOARD_RENDERER -- requirements
Module: tetris_board_renderer

Interface
REQ-001 SHALL have parameter BOARD_X0, default 240, meaning the left pixel column of the playfield.
REQ-002 SHALL have parameter BOARD_Y0, default 80, meaning the top pixel row of the playfield.
REQ-003 SHALL have parameter CELL_LOG2, default 4, meaning the cell edge is 2^CELL_LOG2 pixels (16).
REQ-004 SHALL have port pixclk, input, 1 bit: pixel clock; the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports x_i and y_i, input, 10 bits each: current pixel coordinate from the timing generator.
REQ-007 SHALL have ports de_i, hsync_i and vsync_i, input, 1 bit each: active-video and sync flags, aligned with x_i/y_i.
REQ-008 SHALL have ports wr_en, input, 1 bit; wr_addr, input, 8 bits; wr_data, input, 3 bits: game-logic cell write port.
REQ-009 SHALL have ports red_o, green_o and blue_o, output, 8 bits each: pixel colour for the TMDS encoders.
REQ-010 SHALL have ports de_o, hsync_o and vsync_o, output, 1 bit each: inputs delayed to align with the RGB outputs.
REQ-011 SHALL have port busy, output, 1 bit: board clear in progress.
REQ-012 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the vsync_o rising edge.

Function
REQ-013 SHALL hold a board of 10 columns x 20 rows, 3-bit colour index per cell, at addr = row*10 + col (0..199).
REQ-014 SHALL, on a pixclk edge with wr_en=1, busy=0 and wr_addr<200, write wr_data to the cell; SHALL ignore writes with wr_addr>=200 or busy=1.
REQ-015 SHALL use a synchronous-read board store; a read and write to the same address in the same cycle SHALL return the old data.
REQ-016 SHALL treat a pixel as inside when BOARD_X0<=x_i<BOARD_X0+10*2^CELL_LOG2 and BOARD_Y0<=y_i<BOARD_Y0+20*2^CELL_LOG2, with col=(x_i-BOARD_X0)>>CELL_LOG2 and row=(y_i-BOARD_Y0)>>CELL_LOG2.
REQ-017 SHALL treat a pixel as border when it lies on the 1-pixel ring immediately outside the playfield rectangle.
REQ-018 SHALL use a 2-stage pipeline: stage 1 registers address, inside/border flags and syncs; stage 2 registers RGB and syncs; latency = exactly 2 pixclk cycles for all outputs.
REQ-019 SHALL map the palette as 0=000000, 1=00FFFF, 2=FFFF00, 3=A000F0, 4=00F000, 5=F00000, 6=0000F0, 7=F0A000 (RRGGBB hex).
REQ-020 SHALL output the palette colour for inside pixels, FFFFFF for border pixels, and 000000 for all other pixels.
REQ-021 SHALL force RGB to 000000 whenever the delayed de is 0.
REQ-022 SHALL pulse frame_start for exactly one cycle when vsync_o goes 0->1.

Reset
REQ-023 SHALL, on rst=1, clear all pipeline registers; RGB, de_o, hsync_o, vsync_o and frame_start SHALL read 0 on the cycle after rst is sampled.
REQ-024 SHALL, on rst deassertion, assert busy and clear cells 0..199 to 0, one per cycle, in ascending order; busy SHALL drop after exactly 200 cycles.
REQ-025 SHALL keep rendering during the clear; inside pixels read as 0 (black) while busy=1.
REQ-026 SHALL restart the clear from cell 0 if rst is reasserted mid-clear.

Configuration
REQ-027 SHALL, when macro TETRIS_GRID_LINES_EN is defined, draw inside pixels whose column or row pixel offset within the cell is 0 as 202020 instead of the palette colour.
REQ-028 SHALL, without TETRIS_GRID_LINES_EN, render every inside pixel with its palette colour; latency SHALL be 2 cycles in both builds.

Verification
REQ-029 SHALL be covered: reset, then count cycles -> busy high for exactly 200 cycles, all cells read 0.
REQ-030 SHALL be covered: write addr 0 = 5, drive x=BOARD_X0+3, y=BOARD_Y0+3, de=1 -> RGB = F00000 two cycles later.
REQ-031 SHALL be covered: drive x=BOARD_X0-1, y=BOARD_Y0+5, de=1 -> FFFFFF; x=0, y=0 -> 000000.
REQ-032 SHALL be covered: wr_addr=200 with wr_data=7, then render the last cell (col 9, row 19) -> still 000000; wr_addr=199 with wr_data=7 -> F0A000.
REQ-033 SHALL be covered: toggle vsync_i 0->1 -> vsync_o rises 2 cycles later with a single-cycle frame_start.
REQ-034 SHALL be covered: reassert rst at clear cycle 100 -> busy stays high 200 cycles after the new deassertion.
